// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for loads and stores
//   - response error codes
//   - FSM state enum
//   - lsu_size(): access size in bytes from funct3
package ysyx_24100005_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // Stores share the load encodings for 000/001/010/011, so this covers both.
  function automatic logic [3:0] lsu_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3, we   : access type (we=1 for stores)
//   off          : byte offset of the access within the bus word
//   wdata        : right-aligned store data
//   rdata        : full bus word returned by memory
//   wmask        : byte-lane enables for the store
//   wdata_sh     : store data moved to its byte lanes
//   rdata_ext    : extracted and sign/zero-extended load data
//   misaligned   : offset not a multiple of the access size
//   illegal      : funct3 not supported for this access/XLEN
module ysyx_24100005_lsu_align
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic                       we,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          wmask,
  output logic [XLEN-1:0]            wdata_sh,
  output logic [XLEN-1:0]            rdata_ext,
  output logic                       misaligned,
  output logic                       illegal
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W+2:0]  bit_sh;
  logic [7:0]        lanes8;
  logic [XLEN-1:0]   rdata_sh;
  logic signed [7:0]  s8;
  logic signed [15:0] s16;
  logic signed [31:0] s32;

  assign bit_sh = {off, 3'b000};

  always_comb begin
    lanes8 = 8'h00;
    case (funct3[1:0])
      2'd0:    lanes8 = 8'h01;
      2'd1:    lanes8 = 8'h03;
      2'd2:    lanes8 = 8'h0f;
      default: lanes8 = 8'hff;
    endcase
  end

  assign wmask    = lanes8[NB-1:0] << off;
  assign wdata_sh = wdata << bit_sh;
  assign rdata_sh = rdata >> bit_sh;

  assign s8  = rdata_sh[7:0];
  assign s16 = rdata_sh[15:0];
  assign s32 = rdata_sh[31:0];

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_LB:   rdata_ext = XLEN'(s8);
      F3_LH:   rdata_ext = XLEN'(s16);
      F3_LW:   rdata_ext = XLEN'(s32);
      F3_LD:   rdata_ext = rdata_sh;
      F3_LBU:  rdata_ext = XLEN'(rdata_sh[7:0]);
      F3_LHU:  rdata_ext = XLEN'(rdata_sh[15:0]);
      F3_LWU:  rdata_ext = XLEN'(rdata_sh[31:0]);
      default: rdata_ext = '0;
    endcase
  end

  // Doubleword and lwu exist only on a 64-bit datapath; stores have no
  // unsigned variants.
  assign illegal = (funct3 == F3_BAD) ||
                   (we && funct3[2]) ||
                   ((XLEN == 32) && ((funct3 == F3_LD) || (funct3 == F3_LWU)));

  assign misaligned = |(off & OFF_W'(lsu_size(funct3) - 4'd1));

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit. Takes one access from execute over a
// valid/ready handshake, issues one aligned bus transaction and returns a
// single-cycle response pulse.
//   clk, rst               : clock, synchronous active-high reset
//   req_*                  : access request from execute (req_ready high in IDLE)
//   rsp_valid/rdata/err    : completion pulse, extended load data, error code
//   mem_valid/ready        : bus request handshake
//   mem_we/addr/wmask/wdata: bus request payload (addr word-aligned)
//   mem_rvalid/rdata       : read data or write acknowledge
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; req_ready=1
// REQ    | mem_valid=1, payload held until mem_ready
// WAIT   | request accepted by the bus, waiting for mem_rvalid
// RESP   | rsp_valid=1 for one cycle, then back to IDLE
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wmask,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  lsu_state_t        state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [OFF_W-1:0]  off_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  tmo_cnt_inc;
  logic              timeout_hit;

  logic              sel_we;
  logic [2:0]        sel_funct3;
  logic [OFF_W-1:0]  sel_off;
  logic [XLEN/8-1:0] a_wmask;
  logic [XLEN-1:0]   a_wdata;
  logic [XLEN-1:0]   a_rdata;
  logic              a_misaligned;
  logic              a_illegal;

  // One lane unit serves both phases: in IDLE it checks and shifts the
  // incoming request, afterwards it extracts load data for the latched access.
  assign sel_we     = (state == S_IDLE) ? req_we : we_q;
  assign sel_funct3 = (state == S_IDLE) ? req_funct3 : funct3_q;
  assign sel_off    = (state == S_IDLE) ? req_addr[OFF_W-1:0] : off_q;

  ysyx_24100005_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .funct3     (sel_funct3),
    .we         (sel_we),
    .off        (sel_off),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wmask      (a_wmask),
    .wdata_sh   (a_wdata),
    .rdata_ext  (a_rdata),
    .misaligned (a_misaligned),
    .illegal    (a_illegal)
  );

  // Saturating, so a disabled timeout can never wrap back into a false hit.
  assign tmo_cnt_inc = (&tmo_cnt) ? tmo_cnt : tmo_cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt >= CNT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[OFF_W-1:0];
            tmo_cnt   <= '0;
            req_ready <= 1'b0;
            if (a_illegal) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= ERR_ILLEGAL;
            end else if (a_misaligned) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= ERR_MISALIGN;
            end else begin
              state     <= S_REQ;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wmask <= req_we ? a_wmask : '0;
              mem_wdata <= req_we ? a_wdata : '0;
            end
          end
        end

        S_REQ: begin
          tmo_cnt <= tmo_cnt_inc;
          if (mem_ready) begin
            state     <= S_WAIT;
            mem_valid <= 1'b0;
          end else if (timeout_hit) begin
            state     <= S_RESP;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= ERR_TIMEOUT;
          end
        end

        S_WAIT: begin
          tmo_cnt <= tmo_cnt_inc;
          if (mem_rvalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : a_rdata;
            rsp_err   <= ERR_OK;
          end else if (timeout_hit) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= ERR_TIMEOUT;
          end
        end

        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= ERR_OK;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Scoreboard bench for ysyx_24100005_lsu: one 32-bit instance (TIMEOUT=4)
// and one 64-bit instance share the stimulus signals, gated by sel64.
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  logic        r32_req_ready, r32_rsp_valid, r32_mem_valid, r32_mem_we;
  logic [31:0] r32_rsp_rdata, r32_mem_addr, r32_mem_wdata;
  logic [1:0]  r32_rsp_err;
  logic [3:0]  r32_mem_wmask;

  logic        r64_req_ready, r64_rsp_valid, r64_mem_valid, r64_mem_we;
  logic [63:0] r64_rsp_rdata, r64_mem_wdata;
  logic [31:0] r64_mem_addr;
  logic [1:0]  r64_rsp_err;
  logic [7:0]  r64_mem_wmask;

  ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel64), .req_ready(r32_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .rsp_valid(r32_rsp_valid), .rsp_rdata(r32_rsp_rdata), .rsp_err(r32_rsp_err),
    .mem_valid(r32_mem_valid), .mem_ready(mem_ready & ~sel64), .mem_we(r32_mem_we),
    .mem_addr(r32_mem_addr), .mem_wmask(r32_mem_wmask), .mem_wdata(r32_mem_wdata),
    .mem_rvalid(mem_rvalid & ~sel64), .mem_rdata(mem_rdata[31:0])
  );

  ysyx_24100005_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel64), .req_ready(r64_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(r64_rsp_valid), .rsp_rdata(r64_rsp_rdata), .rsp_err(r64_rsp_err),
    .mem_valid(r64_mem_valid), .mem_ready(mem_ready & sel64), .mem_we(r64_mem_we),
    .mem_addr(r64_mem_addr), .mem_wmask(r64_mem_wmask), .mem_wdata(r64_mem_wdata),
    .mem_rvalid(mem_rvalid & sel64), .mem_rdata(mem_rdata)
  );

  logic        o_req_ready, o_rsp_valid, o_mem_valid, o_mem_we;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [1:0]  o_rsp_err;
  logic [7:0]  o_mem_wmask;

  assign o_req_ready = sel64 ? r64_req_ready : r32_req_ready;
  assign o_rsp_valid = sel64 ? r64_rsp_valid : r32_rsp_valid;
  assign o_rsp_rdata = sel64 ? r64_rsp_rdata : {32'b0, r32_rsp_rdata};
  assign o_rsp_err   = sel64 ? r64_rsp_err   : r32_rsp_err;
  assign o_mem_valid = sel64 ? r64_mem_valid : r32_mem_valid;
  assign o_mem_we    = sel64 ? r64_mem_we    : r32_mem_we;
  assign o_mem_addr  = sel64 ? r64_mem_addr  : r32_mem_addr;
  assign o_mem_wmask = sel64 ? r64_mem_wmask : {4'b0, r32_mem_wmask};
  assign o_mem_wdata = sel64 ? r64_mem_wdata : {32'b0, r32_mem_wdata};

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int   checks   = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   rsp_seen = 0;
  logic mv_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: latency is counted in cycles after the accept edge.
  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (!rst && o_rsp_valid) begin
      rsp_seen++;
      if (rsp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: rsp_valid high with err %b, none expected", o_rsp_err);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e.rdata);
        chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
        chk("rsp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  // Bus monitor: checks the payload on the first cycle of each mem_valid.
  always @(negedge clk) begin : mon_bus
    bus_t e;
    if (o_mem_valid && !mv_prev) begin
      if (bus_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_mem_valid: addr %h, none expected", o_mem_addr);
      end else begin
        e = bus_q.pop_front();
        chk("mem_addr", 64'(o_mem_addr), 64'(e.addr));
        chk("mem_we", 64'(o_mem_we), 64'(e.we));
        chk("mem_wmask", 64'(o_mem_wmask), 64'(e.mask));
        if (e.we) chk("mem_wdata", o_mem_wdata, e.wdata);
      end
    end
    mv_prev = o_mem_valid;
  end

  // rdy < 0 keeps mem_ready low forever; otherwise mem_ready rises rdy cycles
  // after mem_valid and mem_rvalid follows one cycle later.
  task automatic do_req(input logic s64, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] wd, input int rdy,
                        input logic [63:0] rd, input logic [63:0] exp_rd,
                        input logic [1:0] exp_err, input int exp_lat,
                        input logic [7:0] exp_mask, input logic [63:0] exp_wd);
    rsp_t r;
    bus_t b;
    logic has_bus;
    has_bus = (exp_err == 2'b00) || (exp_err == 2'b10);
    sel64 = s64;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    if (has_bus) begin
      b.addr  = s64 ? (addr & 32'hFFFF_FFF8) : (addr & 32'hFFFF_FFFC);
      b.we    = we;
      b.mask  = exp_mask;
      b.wdata = exp_wd;
      bus_q.push_back(b);
    end
    @(negedge clk);
    chk("req_ready_idle", 64'(o_req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    r.rdata = exp_rd;
    r.err   = exp_err;
    r.lat   = exp_lat;
    r.acc   = cyc;
    rsp_q.push_back(r);
    if (has_bus && rdy >= 0) begin
      repeat (rdy) begin @(posedge clk); #1; end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    for (int i = 0; i < 40 && rsp_q.size() != 0; i++) @(negedge clk);
    if (rsp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL rsp_wait: no rsp_valid within 40 cycles for addr %h", addr);
      rsp_q.delete();
    end
    @(negedge clk);
    chk("req_ready_after", 64'(o_req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, 64'd0);
    chk({tag, "_rsp_err"},   64'(o_rsp_err), 64'd0);
    chk({tag, "_mem_valid"}, 64'(o_mem_valid), 64'd0);
    chk({tag, "_mem_wmask"}, 64'(o_mem_wmask), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seen0;
    rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst32");
    sel64 = 1'b1; #1;
    chk_reset_vals("rst64");
    sel64 = 1'b0;
    @(posedge clk); #1;

    // XLEN=32, TIMEOUT=4
    do_req(0, 1, 3'b010, 32'h8000_0004, 64'hDEAD_BEEF, 0, 64'h0, 64'h0, 2'b00, 3, 8'h0F, 64'hDEAD_BEEF);
    do_req(0, 0, 3'b000, 32'h8000_0003, 64'h0, 0, 64'h8011_2233, 64'hFFFF_FF80, 2'b00, 3, 8'h00, 64'h0);
    do_req(0, 0, 3'b100, 32'h8000_0003, 64'h0, 0, 64'h8011_2233, 64'h0000_0080, 2'b00, 3, 8'h00, 64'h0);
    do_req(0, 0, 3'b001, 32'h8000_0002, 64'h0, 0, 64'h8011_2233, 64'hFFFF_8011, 2'b00, 3, 8'h00, 64'h0);
    do_req(0, 0, 3'b101, 32'h8000_0002, 64'h0, 0, 64'h8011_2233, 64'h0000_8011, 2'b00, 3, 8'h00, 64'h0);
    do_req(0, 1, 3'b001, 32'h8000_0001, 64'h1234, 0, 64'h0, 64'h0, 2'b01, 1, 8'h00, 64'h0);
    do_req(0, 0, 3'b011, 32'h8000_0000, 64'h0, 0, 64'h0, 64'h0, 2'b11, 1, 8'h00, 64'h0);
    do_req(0, 1, 3'b000, 32'h1000_0002, 64'hA5, 0, 64'h0, 64'h0, 2'b00, 3, 8'h04, 64'h00A5_0000);
    do_req(0, 1, 3'b001, 32'h1000_0002, 64'h1234, 0, 64'h0, 64'h0, 2'b00, 3, 8'h0C, 64'h1234_0000);
    do_req(0, 1, 3'b100, 32'h1000_0000, 64'h55, 0, 64'h0, 64'h0, 2'b11, 1, 8'h00, 64'h0);
    do_req(0, 0, 3'b010, 32'h0000_0002, 64'h0, 0, 64'h0, 64'h0, 2'b01, 1, 8'h00, 64'h0);
    do_req(0, 0, 3'b111, 32'h0000_0000, 64'h0, 0, 64'h0, 64'h0, 2'b11, 1, 8'h00, 64'h0);
    // timeout with mem_ready stuck low, then mem_ready on the expiry cycle
    do_req(0, 0, 3'b010, 32'h0000_0100, 64'h0, -1, 64'h0, 64'h0, 2'b10, 5, 8'h00, 64'h0);
    do_req(0, 0, 3'b010, 32'h0000_0104, 64'h0, 3, 64'hCAFE_F00D, 64'hCAFE_F00D, 2'b00, 6, 8'h00, 64'h0);

    // reset while waiting for read data: the late mem_rvalid must be ignored
    begin
      bus_t b;
      b.addr = 32'h0000_0200; b.we = 1'b0; b.mask = 8'h00; b.wdata = 64'h0;
      bus_q.push_back(b);
      sel64 = 1'b0; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0200;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen0 = rsp_seen;
      @(negedge clk);
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h1111_2222;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("no_rsp_after_reset", 64'(rsp_seen), 64'(seen0));
    end
    do_req(0, 0, 3'b010, 32'h0000_0300, 64'h0, 0, 64'h7654_3210, 64'h7654_3210, 2'b00, 3, 8'h00, 64'h0);

    // XLEN=64
    do_req(1, 0, 3'b011, 32'h0000_0008, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2'b00, 3, 8'h00, 64'h0);
    do_req(1, 0, 3'b110, 32'h0000_000C, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0123_4567, 2'b00, 3, 8'h00, 64'h0);
    do_req(1, 0, 3'b010, 32'h0000_0004, 64'h0, 1, 64'hFEDC_BA98_0000_0000, 64'hFFFF_FFFF_FEDC_BA98, 2'b00, 4, 8'h00, 64'h0);
    do_req(1, 1, 3'b011, 32'h0000_0010, 64'h1122_3344_5566_7788, 0, 64'h0, 64'h0, 2'b00, 3, 8'hFF, 64'h1122_3344_5566_7788);
    do_req(1, 1, 3'b010, 32'h0000_0014, 64'hAABB_CCDD, 0, 64'h0, 64'h0, 2'b00, 3, 8'hF0, 64'hAABB_CCDD_0000_0000);
    do_req(1, 0, 3'b011, 32'h0000_0004, 64'h0, 0, 64'h0, 64'h0, 2'b01, 1, 8'h00, 64'h0);
    do_req(1, 1, 3'b110, 32'h0000_0000, 64'h0, 0, 64'h0, 64'h0, 2'b11, 1, 8'h00, 64'h0);

    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
Name: ysyx_24100005_lsu

Overview:
- Multi-cycle load/store unit with valid/ready handshakes, replacing the core's combinational DPI memory path.
- Accepts one access from the execute stage and issues a single aligned bus transaction.
- Generates the byte write mask and shifted write data; extracts and sign/zero-extends read data.
- Reports misaligned, illegal-width and timeout errors.
- Parametrised for XLEN 32/64, which adds ld/sd/lwu.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: address width.
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and on error.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address with the low log2(XLEN/8) bits forced to 0.
- mem_wmask  out  XLEN/8  byte-lane enables; 0 for loads.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rvalid  in  1  read data valid, or write acknowledge for stores.
- mem_rdata  in  XLEN  full-word read data.

Behaviour:
- Reset values: state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Accept when req_valid && req_ready; latch we, funct3, addr, wdata.
  - Legal access -> REQ.
  - Illegal or misaligned access -> RESP with the error set; no bus traffic.
- REQ:
  - mem_valid=1; mem_* held stable until mem_ready.
  - mem_ready -> WAIT.
- WAIT:
  - mem_rvalid -> RESP; loads capture the extracted data.
  - mem_rvalid is ignored in every state except WAIT.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency: accept at edge T, mem_valid during T+1. With mem_ready at T+1 and mem_rvalid at T+2, rsp_valid is high at T+3. Minimum is 3 cycles accept-to-response; an error response arrives at T+1.
- Width and legality:
  - size = 1 << funct3[1:0].
  - funct3 000/001/010 signed; 100/101 unsigned.
  - 011 (ld/sd) and 110 (lwu) are legal only when XLEN=64; otherwise err 11.
  - 111 is always err 11.
  - Stores with funct3[2]=1 give err 11.
- Alignment: off = addr[log2(XLEN/8)-1:0]; misaligned iff off mod size != 0.
- Store lanes: mem_wmask = ((1<<size)-1) << off; mem_wdata = req_wdata << 8*off.
- Load extraction: take mem_rdata >> 8*off, truncate to 8*size bits, then sign-extend if funct3[2]=0, else zero-extend.
- Timeout:
  - Counter clears on accept and increments every cycle in REQ or WAIT.
  - Reaching TIMEOUT-1 without the completing handshake -> RESP with err 10.
  - mem_valid drops on leaving REQ.
- Simultaneous events: completing handshake and timeout in the same cycle -> the handshake wins.
- Reset mid-operation: return to IDLE next edge; mem_valid low; any in-flight response is dropped.

Decomposition:
- Package ysyx_24100005_lsu_pkg: funct3 constants (LB..LWU), error codes, state enum, a size-from-funct3 function.
- Sub-module ysyx_24100005_lsu_align (combinational):
  - inputs: funct3, off, wdata, rdata.
  - outputs: wmask, shifted wdata, extended rdata, misaligned, illegal.
- The FSM and timeout counter stay in the top.

Test Plan:
- XLEN=32 sw addr 0x80000004 data 0xDEADBEEF, mem_ready and mem_rvalid on the first cycle -> mem_addr 0x80000004, wmask 1111, wdata 0xDEADBEEF, rsp_valid 3 cycles after accept, err 00.
- lb addr 0x80000003, mem_rdata 0x80112233 -> rsp_rdata 0xFFFFFF80; lbu -> 0x00000080; lh addr 0x80000002 -> 0xFFFF8011.
- sh addr 0x80000001 -> err 01 at T+1; mem_valid never asserted; req_ready high again at T+2.
- XLEN=32 funct3 011 -> err 11. XLEN=64 ld addr 0x8 with mem_rdata 0x0123456789ABCDEF -> rdata equals that value; lwu addr 0xC -> 0x0000000001234567.
- TIMEOUT=4, mem_ready held low -> rsp_valid with err 10 at T+5. Repeat with mem_ready and the timeout expiry in the same cycle -> handshake proceeds to WAIT.
- Assert rst during WAIT, then pulse mem_rvalid -> no rsp_valid; outputs at reset values; next request completes normally.
